mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access (M) stage of the 5-stage pipelined CPU.
- Holds a byte-addressed, little-endian data memory.
- Performs byte/halfword/word stores and loads addressed by the EX-stage ALU result.
- Passes the ALU result through to the write-back stage.
- Provides an independent word-read debug port for the debug unit.

Parameters:
INST_SZ, 32, datapath/word width in bits (fixed at 32 for byte-lane logic).
MEM_SZ, 10, byte-address width; memory holds 2^MEM_SZ bytes = 2^(MEM_SZ-2) words.

Ports:
i_clk  in  1  clock; all memory writes on rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_alu_result_E  in  INST_SZ  byte address for load/store; also passthrough data.
i_operand_b_E  in  INST_SZ  store data (rt value).
i_debug_addr  in  INST_SZ  byte address for debug word read.
i_mem_read_M  in  1  load enable.
i_mem_write_M  in  1  store enable.
i_bhw_M  in  2  access size: 00 byte, 01 halfword, 11 word; 10 treated as word.
o_alu_result_M  out  INST_SZ  combinational copy of i_alu_result_E.
o_read_data_M  out  INST_SZ  load result.
o_debug_mem  out  INST_SZ  word at i_debug_addr.

Behaviour:
- Storage: 2^(MEM_SZ-2) words of INST_SZ bits.
- Address decode:
  - Word index = addr[MEM_SZ-1:2]; bits above MEM_SZ-1 ignored, so addresses wrap modulo 2^MEM_SZ.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Word accesses ignore addr[1:0]; halfword accesses ignore addr[0]. No misalignment trap.
- Reset: while i_rst_n=0, every memory word is cleared to 0 asynchronously, and writes are blocked. Outputs are combinational, so after reset loads and debug reads return 0.
- Store, on rising i_clk when i_mem_write_M=1 and i_rst_n=1:
  - Byte: operand_b[7:0] written to the selected lane.
  - Halfword: operand_b[15:0] written to bits [15:0] or [31:16].
  - Word: full operand_b written.
  - Unselected bytes are unchanged.
- Load (combinational, zero cycles after address valid):
  - i_mem_read_M=1: selected byte/halfword/word, right-justified and sign-extended to INST_SZ.
  - i_mem_read_M=0: o_read_data_M = 0.
- Simultaneous read and write, same cycle: the read returns pre-edge contents; new data is visible right after the write edge.
- Debug port: o_debug_mem = mem[i_debug_addr[MEM_SZ-1:2]].
  - Combinational and always active, independent of i_mem_read_M and i_bhw_M.
  - After a write edge, reflects new data immediately.
- o_alu_result_M = i_alu_result_E, pure wire, unaffected by reset.
- No internal pipeline registers; the M/WB register lives outside this block.

Optional Feature:
Macro MEM_UNSIGNED_LOAD_EN.
- Defined: adds input i_unsigned_M (1 bit). When 1, byte/halfword loads are zero-extended (LBU/LHU); when 0, sign-extended.
- Undefined: no such port; byte/halfword loads are always sign-extended.
- Word loads are unaffected in both cases.

Test Plan:
- Reset then word reads: i_rst_n=0 then 1; debug_addr 0,4,...,36 -> o_debug_mem=0 at every address.
- Word store/load: bhw=11, write i to address 4*i for i=0..9 (one clock each); then mem_read=1 with the same addresses -> o_read_data_M=i; debug_addr=4*i -> o_debug_mem=i; o_alu_result_M tracks the address.
- Byte store: word 0x11223344 at 0x40; byte store 0xAB at 0x42 -> debug at 0x40 reads 0x11AB3344. Byte load at 0x42 -> 0xFFFFFFAB; with MEM_UNSIGNED_LOAD_EN and i_unsigned_M=1 -> 0x000000AB.
- Halfword: halfword store 0x8001 at 0x46 -> word 0x80010000. Halfword load at 0x46 -> 0xFFFF8001; load at 0x44 -> 0x00000000.
- Read-disable and wrap: mem_read=0 -> o_read_data_M=0. Word store 0xDEADBEEF at address 0x404 (MEM_SZ=10) -> debug at 0x004 reads 0xDEADBEEF.
- Reset mid-run: assert i_rst_n=0 asynchronously between edges while mem_write=1 -> all words read 0 immediately; no write during reset.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline M stage with a byte-addressed little-endian data memory,
// sized byte/half/word load-store, ALU passthrough and debug word read port.
// Ports: i_clk, i_rst_n (async low); i_alu_result_E addr/passthrough;
//   i_operand_b_E store data; i_debug_addr debug byte addr;
//   i_mem_read_M, i_mem_write_M, i_bhw_M (00 B, 01 H, 1x W);
//   o_alu_result_M, o_read_data_M, o_debug_mem.
// Option MEM_UNSIGNED_LOAD_EN adds i_unsigned_M (zero-extend B/H loads).
module mem_stage #(
  parameter int INST_SZ = 32,
  parameter int MEM_SZ  = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [INST_SZ-1:0] i_alu_result_E,
  input  logic [INST_SZ-1:0] i_operand_b_E,
  input  logic [INST_SZ-1:0] i_debug_addr,
  input  logic               i_mem_read_M,
  input  logic               i_mem_write_M,
  input  logic [1:0]         i_bhw_M,
`ifdef MEM_UNSIGNED_LOAD_EN
  input  logic               i_unsigned_M,
`endif
  output logic [INST_SZ-1:0] o_alu_result_M,
  output logic [INST_SZ-1:0] o_read_data_M,
  output logic [INST_SZ-1:0] o_debug_mem
);

  localparam int WORDS = 1 << (MEM_SZ - 2);

  logic [INST_SZ-1:0] mem_q [WORDS];

  logic [MEM_SZ-3:0]  widx;
  logic [MEM_SZ-3:0]  didx;
  logic [1:0]         lane;
  logic [3:0]         be;
  logic [INST_SZ-1:0] wdat;
  logic [INST_SZ-1:0] rd_word;
  logic [INST_SZ-1:0] wr_word_d;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic               sext;
  logic               unused_dbg;

  assign widx = i_alu_result_E[MEM_SZ-1:2];
  assign didx = i_debug_addr[MEM_SZ-1:2];
  assign lane = i_alu_result_E[1:0];

  assign o_alu_result_M = i_alu_result_E;
  assign o_debug_mem    = mem_q[didx];
  assign rd_word        = mem_q[widx];

  // Upper address bits wrap away; debug reads are word-granular.
  assign unused_dbg = &{1'b0,
                        i_debug_addr[INST_SZ-1:MEM_SZ],
                        i_debug_addr[1:0]};

  // Replicate store data across lanes; byte enables pick the target.
  always_comb begin
    be   = 4'b1111;
    wdat = i_operand_b_E;
    unique case (i_bhw_M)
      2'b00: begin
        be   = 4'b0001 << lane;
        wdat = {4{i_operand_b_E[7:0]}};
      end
      2'b01: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wdat = {2{i_operand_b_E[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wdat = i_operand_b_E;
      end
    endcase
  end

  always_comb begin
    wr_word_d = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) wr_word_d[8*b +: 8] = wdat[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (i_mem_write_M) begin
      mem_q[widx] <= wr_word_d;
    end
  end

  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

`ifdef MEM_UNSIGNED_LOAD_EN
  assign sext = ~i_unsigned_M;
`else
  assign sext = 1'b1;
`endif

  always_comb begin
    o_read_data_M = '0;
    if (i_mem_read_M) begin
      unique case (i_bhw_M)
        2'b00:
          o_read_data_M = {{(INST_SZ-8){sext & rd_byte[7]}},
                           rd_byte};
        2'b01:
          o_read_data_M = {{(INST_SZ-16){sext & rd_half[15]}},
                           rd_half};
        default:
          o_read_data_M = rd_word;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Hand-computed expectations, checked with immediate assertions.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu;
  logic [31:0] opb;
  logic [31:0] dbg;
  logic        rd;
  logic        wr;
  logic [1:0]  bhw;
  logic        uns;
  logic [31:0] alu_o;
  logic [31:0] rdata;
  logic [31:0] dmem;

  int total = 0;
  int bad   = 0;

  mem_stage #(.INST_SZ(32), .MEM_SZ(10)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_alu_result_E (alu),
    .i_operand_b_E  (opb),
    .i_debug_addr   (dbg),
    .i_mem_read_M   (rd),
    .i_mem_write_M  (wr),
    .i_bhw_M        (bhw),
`ifdef MEM_UNSIGNED_LOAD_EN
    .i_unsigned_M   (uns),
`endif
    .o_alu_result_M (alu_o),
    .o_read_data_M  (rdata),
    .o_debug_mem    (dmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0]  s);
    @(negedge clk);
    alu = a;
    opb = d;
    bhw = s;
    wr  = 1'b1;
    rd  = 1'b0;
    @(posedge clk);
    #1;
    wr  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a,
                      input logic [1:0]  s);
    @(negedge clk);
    alu = a;
    bhw = s;
    rd  = 1'b1;
    wr  = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu   = '0;
    opb   = '0;
    dbg   = '0;
    rd    = 1'b0;
    wr    = 1'b0;
    bhw   = 2'b11;
    uns   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      dbg = 32'(4 * i);
      #1;
      chk($sformatf("rst_dbg%0d", i), dmem, 32'h0);
    end

    for (int i = 0; i < 10; i++)
      store(32'(4 * i), 32'(i), 2'b11);

    for (int i = 0; i < 10; i++) begin
      load(32'(4 * i), 2'b11);
      dbg = 32'(4 * i);
      #1;
      chk($sformatf("wld%0d", i), rdata, 32'(i));
      chk($sformatf("wdbg%0d", i), dmem, 32'(i));
      chk($sformatf("alu%0d", i), alu_o, 32'(4 * i));
    end

    store(32'h40, 32'h11223344, 2'b11);
    store(32'h42, 32'hFFFF_FFAB, 2'b00);
    dbg = 32'h40;
    #1;
    chk("bst_dbg", dmem, 32'h11AB3344);
    load(32'h42, 2'b00);
    chk("lb42", rdata, 32'hFFFFFFAB);
    load(32'h43, 2'b00);
    chk("lb43", rdata, 32'h00000011);
    load(32'h43, 2'b11);
    chk("lw43", rdata, 32'h11AB3344);
`ifdef MEM_UNSIGNED_LOAD_EN
    uns = 1'b1;
    load(32'h42, 2'b00);
    chk("lbu42", rdata, 32'h000000AB);
    uns = 1'b0;
`endif

    store(32'h46, 32'h00008001, 2'b01);
    dbg = 32'h44;
    #1;
    chk("hst_dbg", dmem, 32'h80010000);
    load(32'h46, 2'b01);
    chk("lh46", rdata, 32'hFFFF8001);
    load(32'h47, 2'b01);
    chk("lh47", rdata, 32'hFFFF8001);
    load(32'h44, 2'b01);
    chk("lh44", rdata, 32'h00000000);
`ifdef MEM_UNSIGNED_LOAD_EN
    uns = 1'b1;
    load(32'h46, 2'b01);
    chk("lhu46", rdata, 32'h00008001);
    uns = 1'b0;
`endif

    load(32'h40, 2'b11);
    rd = 1'b0;
    #1;
    chk("rd_off", rdata, 32'h0);

    store(32'h404, 32'hDEADBEEF, 2'b11);
    dbg = 32'h004;
    #1;
    chk("wrap_dbg", dmem, 32'hDEADBEEF);

    store(32'h48, 32'hCAFEF00D, 2'b10);
    load(32'h48, 2'b10);
    chk("bhw10", rdata, 32'hCAFEF00D);

    @(negedge clk);
    alu = 32'h48;
    opb = 32'h12345678;
    bhw = 2'b11;
    rd  = 1'b1;
    wr  = 1'b1;
    dbg = 32'h48;
    #1;
    chk("rw_pre", rdata, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    chk("rw_post", rdata, 32'h12345678);
    chk("rw_dbg", dmem, 32'h12345678);
    wr = 1'b0;

    @(negedge clk);
    alu = 32'h0;
    opb = 32'h55;
    bhw = 2'b11;
    wr  = 1'b1;
    rd  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    dbg = 32'h48;
    #1;
    chk("mrst_dbg48", dmem, 32'h0);
    dbg = 32'h40;
    #1;
    chk("mrst_dbg40", dmem, 32'h0);
    chk("mrst_rd0", rdata, 32'h0);
    chk("mrst_alu", alu_o, 32'h0);
    @(posedge clk);
    #1;
    dbg = 32'h0;
    #1;
    chk("mrst_nowr", dmem, 32'h0);
    @(negedge clk);
    wr    = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst", dmem, 32'h0);
    dbg = 32'h4;
    #1;
    chk("post_rst4", dmem, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
